// File: rtl/pipe_cfg_sequencer.sv
// Bring-up and frame-aligned reconfiguration sequencer for the camera-to-framebuffer pipeline.
// Setting changes are held as pending and only applied, with a pipeline flush, on a start-of-frame.
module pipe_cfg_sequencer #(
  parameter int unsigned CFG_DELAY    = 125000,
  parameter int unsigned CFG_TIMEOUT  = 12500000,
  parameter int unsigned FLUSH_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sof,
  input  logic       i_btn_mode,
  input  logic       i_sw_gaussian,
  input  logic       i_cfg_done,
  output logic       o_cfg_start,
  output logic       o_mode,
  output logic       o_gaussian_enable,
  output logic       o_pipe_flush,
  output logic       o_busy,
  output logic [2:0] o_state
);

  localparam int unsigned WAIT_W  = (CFG_DELAY    > 1) ? $clog2(CFG_DELAY)    : 1;
  localparam int unsigned TO_W    = (CFG_TIMEOUT  > 1) ? $clog2(CFG_TIMEOUT)  : 1;
  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(CFG_DELAY - 32'd1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(CFG_TIMEOUT - 32'd1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 32'd1);
  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1'b1);
  localparam logic [TO_W-1:0]    TO_ONE     = TO_W'(1'b1);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1'b1);

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_CFG   = 3'd1,
    ST_SYNC  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  state_t               r_state;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [TO_W-1:0]      r_cfg_cnt;
  logic [FLUSH_W-1:0]   r_flush_cnt;
  logic                 r_cfg_start;
  logic                 r_mode;
  logic                 r_gauss;
  logic                 r_flush;
  logic                 r_busy;
  logic                 r_pend_mode;
  logic                 r_pend_g;

  state_t               w_state_nxt;
  logic [WAIT_W-1:0]    w_wait_cnt_nxt;
  logic [TO_W-1:0]      w_cfg_cnt_nxt;
  logic [FLUSH_W-1:0]   w_flush_cnt_nxt;
  logic                 w_cfg_start_nxt;
  logic                 w_flush_nxt;
  logic                 w_apply;
  logic                 w_change;

  // Next-state, counter and pulse decode; change detection uses the registered pending values.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_cfg_cnt_nxt   = r_cfg_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    w_cfg_start_nxt = 1'b0;
    w_flush_nxt     = 1'b0;
    w_apply         = 1'b0;
    w_change        = (r_pend_mode != r_mode) || (r_pend_g != r_gauss);
    case (r_state)
      ST_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt     = ST_CFG;
          w_wait_cnt_nxt  = {WAIT_W{1'b0}};
          w_cfg_cnt_nxt   = {TO_W{1'b0}};
          w_cfg_start_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt  = r_wait_cnt + WAIT_ONE;
        end
      end
      ST_CFG: begin
        // done takes priority over a coincident timeout
        if (i_cfg_done) begin
          w_state_nxt     = ST_SYNC;
          w_cfg_cnt_nxt   = {TO_W{1'b0}};
        end else if (r_cfg_cnt == TO_LAST) begin
          w_cfg_cnt_nxt   = {TO_W{1'b0}};
          w_cfg_start_nxt = 1'b1;
        end else begin
          w_cfg_cnt_nxt   = r_cfg_cnt + TO_ONE;
        end
      end
      ST_SYNC: begin
        if (i_sof) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = {FLUSH_W{1'b0}};
          w_flush_nxt     = 1'b1;
          w_apply         = 1'b1;
        end else begin
          w_state_nxt     = ST_SYNC;
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == FLUSH_LAST) begin
          w_state_nxt     = ST_RUN;
          w_flush_cnt_nxt = {FLUSH_W{1'b0}};
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + FLUSH_ONE;
          w_flush_nxt     = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_sof && w_change) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = {FLUSH_W{1'b0}};
          w_flush_nxt     = 1'b1;
          w_apply         = 1'b1;
        end else begin
          w_state_nxt     = ST_RUN;
        end
      end
      default: begin
        w_state_nxt     = ST_WAIT;
        w_wait_cnt_nxt  = {WAIT_W{1'b0}};
        w_cfg_cnt_nxt   = {TO_W{1'b0}};
        w_flush_cnt_nxt = {FLUSH_W{1'b0}};
      end
    endcase
  end

  // State, counters, pending settings and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_WAIT;
      r_wait_cnt  <= {WAIT_W{1'b0}};
      r_cfg_cnt   <= {TO_W{1'b0}};
      r_flush_cnt <= {FLUSH_W{1'b0}};
      r_cfg_start <= 1'b0;
      r_mode      <= 1'b0;
      r_gauss     <= 1'b0;
      r_flush     <= 1'b0;
      r_busy      <= 1'b1;
      r_pend_mode <= 1'b0;
      r_pend_g    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_cfg_cnt   <= w_cfg_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_cfg_start <= w_cfg_start_nxt;
      r_flush     <= w_flush_nxt;
      r_busy      <= (w_state_nxt != ST_RUN);
      r_mode      <= w_apply ? r_pend_mode : r_mode;
      r_gauss     <= w_apply ? r_pend_g : r_gauss;
      r_pend_mode <= r_pend_mode ^ i_btn_mode;
      r_pend_g    <= i_sw_gaussian;
    end
  end

  assign o_cfg_start       = r_cfg_start;
  assign o_mode            = r_mode;
  assign o_gaussian_enable = r_gauss;
  assign o_pipe_flush      = r_flush;
  assign o_busy            = r_busy;
  assign o_state           = r_state;

endmodule

// File: tb/tb_pipe_cfg_sequencer.sv
// Self-checking bench for pipe_cfg_sequencer: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_pipe_cfg_sequencer;

  localparam int CFG_DELAY    = 4;
  localparam int CFG_TIMEOUT  = 20;
  localparam int FLUSH_CYCLES = 3;

  logic       clk;
  logic       i_rst;
  logic       i_sof;
  logic       i_btn_mode;
  logic       i_sw_gaussian;
  logic       i_cfg_done;
  logic       o_cfg_start;
  logic       o_mode;
  logic       o_gaussian_enable;
  logic       o_pipe_flush;
  logic       o_busy;
  logic [2:0] o_state;

  int n_pass;
  int n_total;

  // behavioural model: phase number, time spent in phase, flush cycles still owed
  int m_phase;
  int m_elapsed;
  int m_flush_left;
  bit m_mode, m_g, m_pm, m_pg, m_cfg_start;

  pipe_cfg_sequencer #(
    .CFG_DELAY   (CFG_DELAY),
    .CFG_TIMEOUT (CFG_TIMEOUT),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_sof            (i_sof),
    .i_btn_mode       (i_btn_mode),
    .i_sw_gaussian    (i_sw_gaussian),
    .i_cfg_done       (i_cfg_done),
    .o_cfg_start      (o_cfg_start),
    .o_mode           (o_mode),
    .o_gaussian_enable(o_gaussian_enable),
    .o_pipe_flush     (o_pipe_flush),
    .o_busy           (o_busy),
    .o_state          (o_state)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    bit old_pm, old_pg;
    if (i_rst) begin
      m_phase = 0; m_elapsed = 0; m_flush_left = 0;
      m_mode = 0; m_g = 0; m_pm = 0; m_pg = 0; m_cfg_start = 0;
    end else begin
      old_pm = m_pm;
      old_pg = m_pg;
      m_cfg_start = 0;
      case (m_phase)
        0: begin
          m_elapsed++;
          if (m_elapsed == CFG_DELAY) begin
            m_phase = 1; m_elapsed = 0; m_cfg_start = 1;
          end
        end
        1: begin
          if (i_cfg_done) begin
            m_phase = 2;
          end else begin
            m_elapsed++;
            if (m_elapsed == CFG_TIMEOUT) begin
              m_cfg_start = 1; m_elapsed = 0;
            end
          end
        end
        2: begin
          if (i_sof) begin
            m_mode = old_pm; m_g = old_pg;
            m_phase = 3; m_flush_left = FLUSH_CYCLES;
          end
        end
        3: begin
          m_flush_left--;
          if (m_flush_left == 0) m_phase = 4;
        end
        default: begin
          if (i_sof && (old_pm != m_mode || old_pg != m_g)) begin
            m_mode = old_pm; m_g = old_pg;
            m_phase = 3; m_flush_left = FLUSH_CYCLES;
          end
        end
      endcase
      m_pm = m_pm ^ i_btn_mode;
      m_pg = i_sw_gaussian;
    end
  endtask

  task automatic step(input logic rst, input logic sof, input logic btn);
    i_rst      = rst;
    i_sof      = sof;
    i_btn_mode = btn;
    @(posedge clk);
    model_step();
    #1;
    check_eq("o_state",           int'(o_state),           m_phase);
    check_eq("o_cfg_start",       int'(o_cfg_start),       int'(m_cfg_start));
    check_eq("o_mode",            int'(o_mode),            int'(m_mode));
    check_eq("o_gaussian_enable", int'(o_gaussian_enable), int'(m_g));
    check_eq("o_pipe_flush",      int'(o_pipe_flush),      (m_flush_left > 0) ? 1 : 0);
    check_eq("o_busy",            int'(o_busy),            (m_phase != 4) ? 1 : 0);
    i_sof      = 1'b0;
    i_btn_mode = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    i_rst = 1'b1; i_sof = 1'b0; i_btn_mode = 1'b0;
    i_sw_gaussian = 1'b0; i_cfg_done = 1'b0;

    // 1. bring-up
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_eq("reset_busy", int'(o_busy), 1);
    check_eq("reset_state", int'(o_state), 0);
    idle(3);
    check_eq("cfg_start_before", int'(o_cfg_start), 0);
    idle(1);
    check_eq("cfg_start_cycle4", int'(o_cfg_start), 1);
    check_eq("state_cfg", int'(o_state), 1);
    idle(10);
    i_cfg_done = 1'b1;
    idle(1);
    check_eq("state_sync", int'(o_state), 2);
    idle(4);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < FLUSH_CYCLES; k++) begin
      check_eq("bringup_flush", int'(o_pipe_flush), 1);
      if (k < FLUSH_CYCLES - 1) idle(1);
    end
    idle(1);
    check_eq("bringup_run_flush", int'(o_pipe_flush), 0);
    check_eq("bringup_run_state", int'(o_state), 4);
    check_eq("bringup_run_busy", int'(o_busy), 0);

    // 2. config timeout, then done coincident with a timeout
    i_cfg_done = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    idle(44);
    check_eq("retry_pulse_2", int'(o_cfg_start), 1);
    idle(19);
    check_eq("retry_state", int'(o_state), 1);
    i_cfg_done = 1'b1;
    idle(1);
    check_eq("done_wins_pulse", int'(o_cfg_start), 0);
    check_eq("done_wins_state", int'(o_state), 2);
    idle(2);
    step(1'b0, 1'b1, 1'b0);
    idle(FLUSH_CYCLES + 1);

    // 3. deferred mode change, then a frame with nothing pending
    step(1'b0, 1'b0, 1'b1);
    idle(50);
    check_eq("deferred_mode_hold", int'(o_mode), 0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("deferred_mode_apply", int'(o_mode), 1);
    check_eq("deferred_flush", int'(o_pipe_flush), 1);
    idle(6);
    step(1'b0, 1'b1, 1'b0);
    check_eq("nochange_noflush", int'(o_pipe_flush), 0);
    idle(3);

    // 4. cancelled presses and press coincident with sof
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 1'b0);
    check_eq("cancel_noflush", int'(o_pipe_flush), 0);
    step(1'b0, 1'b1, 1'b1);
    check_eq("coincident_noflush", int'(o_pipe_flush), 0);
    check_eq("coincident_mode", int'(o_mode), 1);
    idle(5);
    step(1'b0, 1'b1, 1'b0);
    check_eq("coincident_later_mode", int'(o_mode), 0);
    check_eq("coincident_later_flush", int'(o_pipe_flush), 1);
    idle(5);

    // 5. gaussian switch moved mid-flush
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    i_sw_gaussian = 1'b1;
    idle(5);
    check_eq("gauss_deferred", int'(o_gaussian_enable), 0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("gauss_applied", int'(o_gaussian_enable), 1);
    check_eq("gauss_flush", int'(o_pipe_flush), 1);
    idle(5);

    // 6. reset on the second flush cycle
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    check_eq("pre_reset_flush", int'(o_pipe_flush), 1);
    step(1'b1, 1'b0, 1'b0);
    check_eq("midflush_rst_flush", int'(o_pipe_flush), 0);
    check_eq("midflush_rst_mode", int'(o_mode), 0);
    check_eq("midflush_rst_state", int'(o_state), 0);
    check_eq("midflush_rst_busy", int'(o_busy), 1);

    // random traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 29) == 0) i_cfg_done = ~i_cfg_done;
      if ($urandom_range(0, 39) == 0) i_sw_gaussian = ~i_sw_gaussian;
      step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_cfg_sequencer.md
Name: pipe_cfg_sequencer

Overview:
Sequences bring-up and run-time reconfiguration of the camera-to-framebuffer pipeline in the 125 MHz processing domain. After reset it waits, triggers camera register configuration, and waits for completion. It then aligns to the first start-of-frame and flushes the pipeline. During operation it defers display-mode and Gaussian-filter changes to frame boundaries, so a setting change never lands mid-frame and the buffered pipeline is always flushed when one does.

Parameters:
CFG_DELAY, 125000, cycles to wait after reset before the first cfg start (1 ms at 125 MHz).
CFG_TIMEOUT, 12500000, cycles to wait for i_cfg_done before re-issuing cfg start (100 ms).
FLUSH_CYCLES, 16, exact number of cycles o_pipe_flush is held high per flush (>=1).

Ports:
i_clk  in  1  125 MHz system clock; all logic on rising edge.
i_rst  in  1  synchronous, active-high reset.
i_sof  in  1  start-of-frame, one-cycle pulse, already in i_clk domain.
i_btn_mode  in  1  debounced mode button, one-cycle pulse per press, i_clk domain.
i_sw_gaussian  in  1  synchronized Gaussian-enable switch level.
i_cfg_done  in  1  camera configuration complete (level, held until next cfg start).
o_cfg_start  out  1  one-cycle pulse starting camera configuration.
o_mode  out  1  applied display mode (0 = color, 1 = greyscale).
o_gaussian_enable  out  1  applied Gaussian filter enable.
o_pipe_flush  out  1  pipeline flush, high for exactly FLUSH_CYCLES cycles.
o_busy  out  1  high in every state except RUN.
o_state  out  3  current state encoding, for status LEDs and debug.

Behaviour:
- State encodings: WAIT=0, CFG=1, SYNC=2, FLUSH=3, RUN=4. Unused codes go to WAIT.
- Reset (i_rst high at an edge): state is WAIT and all counters are 0. o_cfg_start=0, o_mode=0, o_gaussian_enable=0, o_pipe_flush=0, o_busy=1. Pending registers: pend_mode=0, pend_g=0. Reset mid-operation aborts immediately, including mid-flush, with no completion of the flush.
- WAIT: counts cycles. When the counter reaches CFG_DELAY-1, go to CFG and pulse o_cfg_start for that transition cycle only, so it is high on the first CFG cycle.
- CFG: timeout counter runs from 0.
  - i_cfg_done high: go to SYNC.
  - Counter reaches CFG_TIMEOUT-1 without done: re-pulse o_cfg_start, clear the counter, stay in CFG. Retries are unbounded.
  - i_cfg_done sampled in the same cycle as the timeout: done wins, no re-pulse.
- SYNC: waits for i_sof. On i_sof, go to FLUSH and load the applied settings: o_mode<=pend_mode, o_gaussian_enable<=pend_g.
- FLUSH: o_pipe_flush is high on each of exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the triggering i_sof. It falls and the state becomes RUN on the following cycle. i_sof during FLUSH is ignored.
- Pending tracking, active in every state except under reset:
  - i_btn_mode pulse: pend_mode<=~pend_mode. Two presses between frame boundaries cancel out.
  - pend_g<=i_sw_gaussian every cycle.
- RUN:
  - change = (pend_mode != o_mode) or (pend_g != o_gaussian_enable), evaluated on registered pend values.
  - On i_sof with change=1: apply settings as in SYNC and go to FLUSH.
  - On i_sof with change=0: no action, no flush.
- Simultaneous events:
  - i_btn_mode in the same cycle as i_sof updates pend_mode but is not applied until the next i_sof.
  - Changes during WAIT, CFG or FLUSH are held in pend and applied at the first qualifying boundary (SYNC's i_sof, or RUN's i_sof).
- o_busy = (state != RUN). All outputs are registered.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit.

Test Plan:
Setup: CFG_DELAY=4, CFG_TIMEOUT=20, FLUSH_CYCLES=3.
1. Bring-up: release i_rst, raise i_cfg_done 10 cycles after o_cfg_start, pulse i_sof 5 cycles later -> o_cfg_start high exactly 1 cycle, on cycle 4 after reset. o_pipe_flush high exactly 3 cycles starting the cycle after i_sof. o_state sequence 0,1,2,3,4. o_busy=0 once in RUN.
2. Config timeout: hold i_cfg_done low -> o_cfg_start pulses every 20 cycles, state stays 1. Raise done on the same cycle as a timeout -> no new pulse, next state is 2.
3. Deferred mode change: in RUN, pulse i_btn_mode, then i_sof 50 cycles later -> o_mode stays 0 until the cycle after i_sof, then becomes 1 together with the start of a 3-cycle flush. An i_sof with no pending change -> no flush.
4. Cancel and coincidence: two i_btn_mode pulses before i_sof -> no flush, o_mode unchanged. A press coincident with i_sof -> applied only at the next i_sof.
5. Gaussian during flush: toggle i_sw_gaussian to 1 mid-FLUSH -> o_gaussian_enable stays 0 through FLUSH and becomes 1 at the next RUN i_sof, with a flush.
6. Reset mid-flush: assert i_rst on the 2nd flush cycle -> next cycle o_pipe_flush=0, o_mode=0, o_state=0, o_busy=1.
